systolic_array_input_feeder: RTL

- Downstream stage of the OBI systolic-array register wrapper: receives 32-bit data words the wrapper decodes from bus writes, packs them into SA_SIZE-element rows, and buffers the rows in a small FIFO.
- Drives the west edge of the systolic array with a diagonally skewed stream: lane k is delayed k advances.
- Provides backpressure to the wrapper. The wrapper withholds gnt while wr_ready_o is low.

---
 rtl/systolic_array_input_feeder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/systolic_array_input_feeder.sv
// Packs 32-bit words into SA_SIZE-element rows, buffers them in a row FIFO and feeds the array's west edge with a diagonal skew.
// Optional statistics counters are enabled by defining SYSTOLIC_FEEDER_STATS_EN.
module systolic_array_input_feeder #(
  parameter int SA_SIZE    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_n,
  input  logic                             wr_valid_i,
  input  logic [31:0]                      wr_data_i,
  output logic                             wr_ready_o,
  input  logic                             flush_i,
  input  logic                             advance_i,
  output logic [SA_SIZE*DATA_WIDTH-1:0]    a_data_o,
  output logic [SA_SIZE-1:0]               a_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count_o,
`ifdef SYSTOLIC_FEEDER_STATS_EN
  output logic [15:0]                      underflow_cnt_o,
  output logic [15:0]                      rows_fed_cnt_o,
`endif
  output logic                             busy_o
);

  localparam int WPR = SA_SIZE / 4;
  localparam int WW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int RW  = SA_SIZE * DATA_WIDTH;

  logic [WW-1:0] word_idx;
  logic [RW-1:0] row_asm;
  logic [RW-1:0] row_next;
  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          accept;
  logic          last_word;
  logic          push;
  logic          fifo_empty;
  logic          inject;
  logic          pop;
  logic [RW-1:0] inj_row;
  logic          inj_valid;

  // Handshake: a word transfers on a clock edge where wr_valid_i and wr_ready_o are both high;
  // wr_ready_o depends only on the row count and flush_i, never on wr_valid_i.
  assign wr_ready_o = (count < CW'(FIFO_DEPTH)) && !flush_i;
  assign accept     = wr_valid_i && wr_ready_o;
  assign last_word  = (word_idx == WW'(WPR - 1));
  assign push       = accept && last_word;
  assign fifo_empty = (count == '0);
  assign inject     = advance_i && !flush_i;
  assign pop        = inject && !fifo_empty;
  assign inj_valid  = !fifo_empty;
  assign inj_row    = fifo_empty ? '0 : mem[rd_ptr];

  // The final word goes straight into the pushed row, so row_next carries it.
  always_comb begin
    row_next = row_asm;
    for (int w = 0; w < WPR; w++) begin
      if (word_idx == WW'(w)) row_next[32*w +: 32] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      word_idx <= '0;
      row_asm  <= '0;
      wr_ptr   <= '0;
    end else if (flush_i) begin
      word_idx <= '0;
      wr_ptr   <= '0;
    end else if (accept) begin
      row_asm  <= row_next;
      word_idx <= last_word ? '0 : word_idx + WW'(1);
      if (last_word) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= row_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Lane k holds k+1 stages; its last stage is the registered lane output.
  for (genvar k = 0; k < SA_SIZE; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] sd [k+1];
    logic [k:0]            sv;

    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= k; j++) sd[j] <= '0;
        sv <= '0;
      end else if (flush_i) begin
        for (int j = 0; j <= k; j++) sd[j] <= '0;
        sv <= '0;
      end else if (inject) begin
        sd[0] <= inj_row[k*DATA_WIDTH +: DATA_WIDTH];
        sv[0] <= inj_valid;
        for (int j = 1; j <= k; j++) begin
          sd[j] <= sd[j-1];
          sv[j] <= sv[j-1];
        end
      end
    end

    assign a_data_o[k*DATA_WIDTH +: DATA_WIDTH] = sd[k];
    assign a_valid_o[k]                         = sv[k];
  end

  assign fifo_count_o = count;
  assign busy_o       = !fifo_empty || (word_idx != '0) || (|a_valid_o);

`ifdef SYSTOLIC_FEEDER_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt_o <= '0;
      rows_fed_cnt_o  <= '0;
    end else if (flush_i) begin
      underflow_cnt_o <= '0;
      rows_fed_cnt_o  <= '0;
    end else if (inject) begin
      if (fifo_empty) begin
        if (underflow_cnt_o != 16'hFFFF) underflow_cnt_o <= underflow_cnt_o + 16'd1;
      end else begin
        rows_fed_cnt_o <= rows_fed_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule
